// File: rtl/seq_pkg.sv
// Encodings and defaults shared between the serializer and the downstream
// 1100 detector, so both sides agree on state names and timing.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_e;

  typedef enum logic [1:0] {
    M0 = 2'd0,
    M1 = 2'd1,
    M2 = 2'd2,
    M3 = 2'd3
  } match_state_e;

  localparam int unsigned GAP_DEFAULT = 4;
  localparam int unsigned MAX_LEN     = 16;

  // Lengths above the payload width are treated as a full 16-bit frame.
  function automatic logic [4:0] clamp_len(input logic [4:0] len);
    return (len > 5'(MAX_LEN)) ? 5'(MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/seq_match_model.sv
// 1100 sequence model advanced once per strobe; also usable as a scoreboard
// reference for the detector.
module seq_match_model
  import seq_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         advance,
  input  logic         sample_bit,
  output match_state_e state,
  output logic [3:0]   match_cnt
);

  match_state_e state_next;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    if (advance) begin
      case (state)
        M0:      state_next = sample_bit ? M1 : M0;
        M1:      state_next = sample_bit ? M2 : M0;
        M2:      state_next = sample_bit ? M2 : M3;
        M3:      state_next = sample_bit ? M1 : M0;
        default: state_next = M0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= M0;
      match_cnt <= 4'd0;
    end else begin
      state <= state_next;
      if (advance && state == M3 && !sample_bit)
        match_cnt <= match_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/seq_serializer.sv
// Serializes an MSB-first frame onto sw_out, issuing one strobe per bit with
// a fixed setup/strobe/hold cadence, and counts 1100 patterns on the way out.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int unsigned GAP = GAP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] data,
  input  logic [4:0]  len,
  output logic        sw_out,
  output logic        strobe,
  output logic        busy,
  output logic        done,
  output logic [3:0]  match_cnt
);

  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

  seq_state_e  state, state_next;
  logic [15:0] frame;
  logic [3:0]  bit_idx;
  logic [7:0]  gap_cnt;
  logic [4:0]  eff_len;
  logic [3:0]  first_idx;

  assign eff_len   = clamp_len(len);
  assign first_idx = 4'(eff_len - 5'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = (eff_len == 5'd0) ? ST_DONE : ST_SETUP;
      ST_SETUP:  state_next = ST_STROBE;
      ST_STROBE: state_next = ST_HOLD;
      ST_HOLD:   if (gap_cnt == GAP_LAST)
                   state_next = (bit_idx == 4'd0) ? ST_DONE : ST_SETUP;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // sw_out is registered and only changes when a new bit is launched, so it
  // stays put through SETUP/STROBE/HOLD/DONE and while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame   <= 16'd0;
      bit_idx <= 4'd0;
      gap_cnt <= 8'd0;
      sw_out  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start && eff_len != 5'd0) begin
          frame   <= data;
          bit_idx <= first_idx;
          sw_out  <= data[first_idx];
        end
        ST_STROBE: gap_cnt <= 8'd0;
        ST_HOLD: if (gap_cnt == GAP_LAST) begin
          if (bit_idx != 4'd0) begin
            bit_idx <= bit_idx - 4'd1;
            sw_out  <= frame[bit_idx - 4'd1];
          end
        end else begin
          gap_cnt <= gap_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign strobe = (state == ST_STROBE);
  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);

  match_state_e match_state;

  seq_match_model u_match (
    .clk        (clk),
    .rst        (rst),
    .advance    (strobe),
    .sample_bit (sw_out),
    .state      (match_state),
    .match_cnt  (match_cnt)
  );

endmodule

// File: tb/tb_seq_serializer.sv
// Directed and random frames checked cycle by cycle against a timing and
// 1100-history model derived from the frame rules.
module tb_seq_serializer;

  localparam int P = 2 + int'(seq_pkg::GAP_DEFAULT);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] data = 16'd0;
  logic [4:0]  len = 5'd0;
  logic        sw_out, strobe, busy, done;
  logic [3:0]  match_cnt;

  int compared = 0;
  int mismatched = 0;

  // reference model: last four transmitted bits, total match count, last bit
  logic [3:0] hist = 4'd0;
  int         ref_cnt = 0;
  logic       last_bit = 1'b0;

  always #5 clk = ~clk;

  seq_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data      (data),
    .len       (len),
    .sw_out    (sw_out),
    .strobe    (strobe),
    .busy      (busy),
    .done      (done),
    .match_cnt (match_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    compared++;
    assert (obs === expd) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  // longest suffix of the bit history that is a prefix of 1100
  function automatic logic [1:0] expect_mstate(input logic [3:0] h);
    if (h[2:0] == 3'b110) return 2'd3;
    if (h[1:0] == 2'b11)  return 2'd2;
    if (h[0])             return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_reset();
    hist = 4'd0;
    ref_cnt = 0;
    last_bit = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] d, input logic [4:0] l,
                           input bit mid_start, input int rst_after);
    int   eff = (l > 5'd16) ? 16 : int'(l);
    int   span = eff * P;
    int   strobes = 0;
    bit   pend = 0;
    bit   exp_strobe;
    logic exp_bit;
    start = 1'b1; data = d; len = l;
    @(posedge clk); #1;
    start = 1'b0; data = 16'($urandom); len = 5'($urandom);
    for (int c = 0; c <= span + 1; c++) begin
      if (pend) begin
        check("mstate", 32'(dut.u_match.state), 32'(expect_mstate(hist)));
        check("match_cnt", 32'(match_cnt), 32'(ref_cnt % 16));
        pend = 0;
      end
      exp_strobe = 0;
      if (c <= span) begin
        exp_strobe = (c < span) && (c % P == 1);
        check("busy", 32'(busy), 32'd1);
        check("done", 32'(done), 32'(c == span));
        check("strobe", 32'(strobe), 32'(exp_strobe));
        exp_bit = (eff > 0) ? d[eff - 1 - ((c < span) ? c / P : eff - 1)] : last_bit;
        check("sw_out", 32'(sw_out), 32'(exp_bit));
        if (exp_strobe) begin
          hist = {hist[2:0], exp_bit};
          if (hist == 4'b1100) ref_cnt++;
          strobes++;
          pend = 1;
        end
        if (c == span) last_bit = exp_bit;
      end else begin
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_strobe", 32'(strobe), 32'd0);
        check("idle_sw_out", 32'(sw_out), 32'(last_bit));
        check("idle_match_cnt", 32'(match_cnt), 32'(ref_cnt % 16));
      end
      if (rst_after > 0 && exp_strobe && strobes == rst_after) begin
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strobe", 32'(strobe), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sw_out", 32'(sw_out), 32'd0);
        check("rst_match_cnt", 32'(match_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3 * P; k++) begin
          @(posedge clk); #1;
          check("post_rst_strobe", 32'(strobe), 32'd0);
          check("post_rst_busy", 32'(busy), 32'd0);
        end
        return;
      end
      start = mid_start && (c == 3);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_strobe", 32'(strobe), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sw_out", 32'(sw_out), 32'd0);
    check("reset_match_cnt", 32'(match_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_frame(16'h000C, 5'd4, 0, 0);
    check("first_frame_cnt", 32'(match_cnt), 32'd1);
    run_frame(16'h00CC, 5'd8, 0, 0);
    check("cc_frame_cnt", 32'(match_cnt), 32'd3);
    run_frame(16'h001C, 5'd5, 0, 0);
    check("1c_frame_cnt", 32'(match_cnt), 32'd4);
    run_frame(16'($urandom), 5'd0, 0, 0);
    run_frame(16'($urandom), 5'd20, 0, 0);
    run_frame(16'($urandom), 5'd6, 1, 0);

    for (int i = 0; i < 8; i++)
      run_frame(16'($urandom), 5'($urandom_range(0, 31)), 0, 0);

    run_frame(16'hCCCC, 5'd8, 0, 2);
    run_frame(16'h000C, 5'd4, 0, 0);
    check("post_rst_frame_cnt", 32'(match_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_serializer.md
SEQ_SERIALIZER -- requirements
Module: seq_serializer

Interface
REQ-001 SHALL have parameter GAP, default 4, meaning HOLD-phase cycles after each strobe, legal range 1..255.
REQ-002 SHALL have port clk  input  1  the single system clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  frame request, sampled only in IDLE.
REQ-005 SHALL have port data  input  16  frame payload; bit len-1 is transmitted first.
REQ-006 SHALL have port len  input  5  frame length in bits; 0 means an empty frame; 17..31 are clamped to 16.
REQ-007 SHALL have port sw_out  output  1  serial bit to the downstream detector's sw input.
REQ-008 SHALL have port strobe  output  1  one-cycle sample pulse to the downstream detector's edge input.
REQ-009 SHALL have port busy  output  1  high while a frame is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a frame completes.
REQ-011 SHALL have port match_cnt  output  4  running count of 1100 occurrences in all transmitted bits.

Function
REQ-012 SHALL implement the FSM states IDLE, SETUP, STROBE, HOLD and DONE.
REQ-013 SHALL, in IDLE with start=1 and effective len>0, latch data and len, drive sw_out=data[len-1], and enter SETUP on the next edge.
REQ-014 SHALL, in IDLE with start=1 and len=0, enter DONE directly and emit no strobe.
REQ-015 SHALL remain in SETUP exactly 1 cycle with sw_out stable and strobe=0.
REQ-016 SHALL hold STROBE exactly 1 cycle with strobe=1 and sw_out unchanged.
REQ-017 SHALL hold HOLD exactly GAP cycles with sw_out unchanged.
REQ-018 SHALL, at the end of HOLD, enter DONE if no bits remain; otherwise it SHALL drive the next lower bit on sw_out and enter SETUP.
REQ-019 SHALL pulse done for 1 cycle in DONE and then return to IDLE.
REQ-020 SHALL assert busy in SETUP, STROBE, HOLD and DONE; busy SHALL be 0 in IDLE.
REQ-021 SHALL ignore start whenever the FSM is not in IDLE.
REQ-022 SHALL give a per-bit period of exactly 2+GAP cycles; a frame of len>0 SHALL occupy len*(2+GAP) cycles followed by 1 DONE cycle.
REQ-023 SHALL advance a 2-bit match model (M0..M3) once per strobe using the transmitted bit: M0: 1->M1, 0->M0; M1: 1->M2, 0->M0; M2: 0->M3, 1->M2; M3: 0->M0, 1->M1.
REQ-024 SHALL increment match_cnt by 1, modulo 16, on a strobe where the model is in M3 and the bit is 0.
REQ-025 SHALL keep the match model and match_cnt across frames; only rst SHALL clear them.
REQ-026 SHALL hold sw_out at its last value while in IDLE.

Reset
REQ-027 SHALL, on rst, immediately force the FSM to IDLE, the match model to M0, and sw_out, strobe, busy, done and match_cnt to 0, including in the middle of a frame.
REQ-028 SHALL emit no strobe during or after a mid-frame reset until a new start is accepted.

Structure
REQ-029 SHALL take the FSM state encoding, the match-model state encoding and the default GAP from a shared package, seq_pkg, which is shared with the detector.
REQ-030 SHALL contain one sub-module, seq_match_model, implementing REQ-023 and REQ-024, so that it is reusable as a scoreboard reference.

Verification
REQ-031 SHALL cover: data=0x000C, len=4, GAP=4 -> sw_out sequence 1,1,0,0 on 4 strobes spaced 6 cycles apart, done pulse after 24 busy cycles, match_cnt=1.
REQ-032 SHALL cover: data=0x00CC, len=8 -> 8 strobes, match_cnt increases by 2.
REQ-033 SHALL cover: data=0x001C, len=5 (bits 1,1,1,0,0) -> model path M1,M2,M2,M3,M0, match_cnt increases by 1.
REQ-034 SHALL cover: len=0 with start -> done 1 cycle later, zero strobes; len=20 -> exactly 16 strobes.
REQ-035 SHALL cover: start pulsed during busy -> ignored, strobe count equals the first frame's length only.
REQ-036 SHALL cover: rst asserted after the 2nd strobe -> busy, strobe and match_cnt are 0 at once, with no further strobes.
